stage2_sequencer: RTL and testbench
===================================

// Module: stage2_sequencer
// PURPOSE
//  Controller that sequences one Stage2 layer (S2_NUM MAC/round/sigmoid lanes fed one serial input per cycle).
//  Accepts a stage-1 result vector, clears the MACs, then streams S1_NUM inputs plus matching weight rows from a
//  synchronous weight ROM. It waits for MAC ready, captures the layer output and presents it on a valid/ready port.
// PARAMETERS
//  S1_NUM        8   inputs per vector = MAC beats per evaluation
//  S2_NUM        8   neurons/lanes in Stage2
//  DATA_WIDTH    8   Q4.4 signed sample/weight width
//  DRAIN_TIMEOUT 16  max cycles in DRAIN waiting for mac_rdy before error
//  AW (local)        $clog2(S1_NUM), min 1; width of w_addr
// PORTS
//  clk          in   1               single clock, rising edge
//  reset        in   1               synchronous, active-low
//  in_valid     in   1               stage-1 vector valid
//  in_ready     out  1               sequencer can accept a vector
//  in_vector    in   DW x S1_NUM     signed stage-1 outputs
//  w_addr       out  AW              weight ROM row address (row k = weights of input k for all lanes)
//  w_rdata      in   DW x S2_NUM     ROM row data, valid 1 cycle after w_addr
//  mac_reset    out  1               to Stage2 reset, active-low; clears accumulators
//  mac_enable   out  1               to Stage2 enable
//  mac_inp      out  DW              to Stage2 inp
//  mac_weights  out  DW x S2_NUM     to Stage2 weights
//  mac_rdy      in   1               AND of all lane rdy
//  layer_out    in   DW x S2_NUM     Stage2 out_vector
//  out_valid    out  1               result valid
//  out_ready    in   1               downstream accepts
//  out_vector   out  DW x S2_NUM     registered layer result
//  busy         out  1               state != IDLE
//  err          out  1               sticky drain timeout; cleared only by reset
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE, beat cnt=0, timeout cnt=0, out_vector=0, out_valid=0, err=0.
//   mac_reset=0 while reset is low (combinational pass-through). All other outputs are 0.
//  Reset mid-operation aborts; no partial result is emitted.
//  States: IDLE -> CLEAR -> FETCH -> STREAM -> DRAIN -> OUTPUT -> IDLE.
//  IDLE: in_ready=1. On in_valid&&in_ready, latch in_vector into buffer, go to CLEAR.
//   in_ready=0 in all other states; in_valid is ignored there.
//  CLEAR (1 cyc): mac_reset=0, mac_enable=0.
//  FETCH (1 cyc): w_addr=0, mac_enable=0.
//  STREAM (S1_NUM cyc, beat k=0..S1_NUM-1): mac_enable=1, mac_inp=buf[k], mac_weights=w_rdata (row k).
//   w_addr=k+1, saturating at S1_NUM-1 on the last beat (never wraps to 0).
//   k advances every cycle; no stalls.
//  DRAIN: mac_enable=0. mac_rdy is sampled only here; mac_rdy high outside DRAIN is ignored.
//   On mac_rdy: out_vector<=layer_out, out_valid<=1, go to OUTPUT.
//   Timeout: if DRAIN_TIMEOUT cycles elapse without mac_rdy, set err=1 and go to IDLE with no output.
//  OUTPUT: out_vector/out_valid held stable until out_ready. On out_valid&&out_ready: out_valid<=0, go to IDLE.
//   out_ready while out_valid=0 has no effect.
//  Latency: handshake at cycle 0 -> CLEAR@1, FETCH@2, STREAM@3..S1_NUM+2, DRAIN from S1_NUM+3;
//   out_valid asserts the cycle after mac_rdy is sampled. Minimum back-to-back input spacing is S1_NUM+5 cycles.
//  Arithmetic: none; samples and weights pass through unmodified (signed, DW bits). Counters are unsigned.
// STRUCTURE
//  Shared package mlp_pkg: DATA_WIDTH default, seq_state_e enum (IDLE..OUTPUT),
//   typedef sample_t = logic signed [DATA_WIDTH-1:0].
//  One sub-module: vec_shift_buf (parallel load of S1_NUM samples, shift one per STREAM beat, head = mac_inp).
//  FSM, beat counter and timeout counter stay in the top module.
// TESTING (S1_NUM=8, S2_NUM=8, DW=8; Stage2 behavioural model with rdy 2 cyc after enable falls)
//  1 reset low 3 cyc mid-STREAM -> state IDLE, out_valid=0, mac_reset=0 during reset, in_ready=1 after.
//  2 in_vector={1..8} (0x10..0x80), ROM row k=all k+1 -> mac_inp seq 0x10..0x80 on cycles 3..10,
//    w_addr 0,1..7,7, mac_weights row k aligned with beat k.
//  3 model rdy at cycle 13 -> out_valid@14, out_vector=layer_out captured at 13; out_ready held 0 for 5 cyc
//    -> out_vector/out_valid stable throughout.
//  4 in_valid held high throughout -> second vector accepted only on return to IDLE; count in_ready pulses = 2.
//  5 mac_rdy never asserted -> err=1 exactly 16 cyc after DRAIN entry, no out_valid; err persists until reset.
//  6 mac_rdy forced high during STREAM -> ignored, no early capture; capture occurs only in DRAIN.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types for the MLP datapath: default sample width, signed sample type and
// the Stage2 sequencer state encoding.
package mlp_pkg;

  localparam int DATA_WIDTH = 8;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FETCH  = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_OUTPUT = 3'd5
  } seq_state_e;

endpackage

// File: rtl/vec_shift_buf.sv
// Holds one stage-1 vector; loads all samples in parallel, then shifts one sample
// per beat so that element k sits at the head on beat k.
module vec_shift_buf #(
  parameter int N  = 8,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            shift,
  input  logic [N*DW-1:0] load_data,
  output logic [DW-1:0]   head
);

  logic [N*DW-1:0] data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift) begin
      data <= data >> DW;
    end
  end

  assign head = data[DW-1:0];

endmodule

// File: rtl/stage2_sequencer.sv
// Sequences one Stage2 layer evaluation: accept a vector, clear the MACs, stream
// samples with their weight rows, wait for the lanes, then hand the result downstream.
module stage2_sequencer #(
  parameter  int S1_NUM        = 8,
  parameter  int S2_NUM        = 8,
  parameter  int DATA_WIDTH    = mlp_pkg::DATA_WIDTH,
  parameter  int DRAIN_TIMEOUT = 16,
  localparam int AW            = (S1_NUM > 1) ? $clog2(S1_NUM) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH*S1_NUM-1:0] in_vector,
  output logic [AW-1:0]                w_addr,
  input  logic [DATA_WIDTH*S2_NUM-1:0] w_rdata,
  output logic                         mac_reset,
  output logic                         mac_enable,
  output logic [DATA_WIDTH-1:0]        mac_inp,
  output logic [DATA_WIDTH*S2_NUM-1:0] mac_weights,
  input  logic                         mac_rdy,
  input  logic [DATA_WIDTH*S2_NUM-1:0] layer_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH*S2_NUM-1:0] out_vector,
  output logic                         busy,
  output logic                         err,
  output logic [2:0]                   dbg_state
);

  import mlp_pkg::*;

  localparam int            TW        = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_BEAT = AW'(S1_NUM - 1);
  localparam logic [TW-1:0] LAST_TMO  = TW'(DRAIN_TIMEOUT - 1);

  seq_state_e              state, state_nxt;
  logic [AW-1:0]           beat_cnt;
  logic [TW-1:0]           tmo_cnt;
  logic                    accept;
  logic                    capture;
  logic                    in_stream;
  logic [DATA_WIDTH-1:0]   head;

  // Both ports use valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; a producer holds valid and its data stable until then.
  assign accept    = in_valid & in_ready;
  assign capture   = (state == S_DRAIN) & mac_rdy;
  assign in_stream = (state == S_STREAM);

  vec_shift_buf #(
    .N  (S1_NUM),
    .DW (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .shift     (in_stream),
    .load_data (in_vector),
    .head      (head)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_STREAM;
      S_STREAM: if (beat_cnt == LAST_BEAT) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (mac_rdy)                  state_nxt = S_OUTPUT;
        else if (tmo_cnt == LAST_TMO) state_nxt = S_IDLE;
      end
      S_OUTPUT: if (out_valid && out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_cnt   <= '0;
      tmo_cnt    <= '0;
      out_vector <= '0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (in_stream) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + AW'(1);
      else           beat_cnt <= '0;

      if (state == S_DRAIN) tmo_cnt <= tmo_cnt + TW'(1);
      else                  tmo_cnt <= '0;

      if (capture) begin
        out_vector <= layer_out;
        out_valid  <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid  <= 1'b0;
      end

      if ((state == S_DRAIN) && !mac_rdy && (tmo_cnt == LAST_TMO)) err <= 1'b1;
    end
  end

  // ROM is one cycle behind the address, so the address runs one row ahead of the
  // beat and parks on the last row rather than wrapping.
  assign w_addr      = !in_stream ? '0 :
                       (beat_cnt == LAST_BEAT) ? LAST_BEAT : beat_cnt + AW'(1);
  assign in_ready    = reset & (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign mac_reset   = reset & (state != S_CLEAR);
  assign mac_enable  = in_stream;
  assign mac_inp     = in_stream ? head : '0;
  assign mac_weights = in_stream ? w_rdata : '0;
  assign dbg_state   = state;

endmodule

// File: tb/tb_stage2_sequencer.sv
// Bench for stage2_sequencer: a timeline model of one layer evaluation, derived from
// the handshake cycle, checked against randomized vectors, ROM rows and lane timing.
module tb_stage2_sequencer;

  localparam int S1 = 8;
  localparam int S2 = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [S1*DW-1:0] in_vector = '0;
  logic [2:0]      w_addr;
  logic [S2*DW-1:0] w_rdata = '0;
  logic            mac_reset;
  logic            mac_enable;
  logic [DW-1:0]   mac_inp;
  logic [S2*DW-1:0] mac_weights;
  logic            mac_rdy = 1'b0;
  logic [S2*DW-1:0] layer_out = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [S2*DW-1:0] out_vector;
  logic            busy;
  logic            err;
  logic [2:0]      dbg_state;

  stage2_sequencer #(
    .S1_NUM(S1), .S2_NUM(S2), .DATA_WIDTH(DW), .DRAIN_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_vector(in_vector), .w_addr(w_addr), .w_rdata(w_rdata),
    .mac_reset(mac_reset), .mac_enable(mac_enable), .mac_inp(mac_inp),
    .mac_weights(mac_weights), .mac_rdy(mac_rdy), .layer_out(layer_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_vector(out_vector),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // synchronous weight ROM model
  logic [S2*DW-1:0] rom [S1];
  always @(posedge clk) w_rdata <= rom[w_addr];

  int vec_cnt = 0;
  int err_cnt = 0;
  int acc_cnt = 0;
  logic err_model = 1'b0;
  logic [S2*DW-1:0] exp_q[$];

  always @(posedge clk) if (reset && in_valid && in_ready) acc_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rom_random();
    for (int k = 0; k < S1; k++) rom[k] = {$urandom, $urandom};
  endtask

  // One evaluation, starting in IDLE. rdy_dly = DRAIN cycle index where the lanes
  // report ready (>=16 means never); hold = cycles out_ready stays low.
  task automatic run_txn(input logic [63:0] vec, input int rdy_dly, input int hold,
                         input bit keep_valid, input bit noisy);
    logic [63:0] expv;
    bool_t_dummy: begin end
    in_vector = vec;
    in_valid  = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    step();
    if (!keep_valid) in_valid = 1'b0;
    #1;
    chk("clear_mac_reset", mac_reset, 0);
    chk("clear_enable", mac_enable, 0);
    chk("clear_in_ready", in_ready, 0);
    step();
    #1;
    chk("fetch_addr", w_addr, 0);
    chk("fetch_enable", mac_enable, 0);
    for (int k = 0; k < S1; k++) begin
      step();
      mac_rdy = noisy;
      #1;
      chk("stream_enable", mac_enable, 1);
      chk("stream_inp", mac_inp, vec[k*DW +: DW]);
      chk("stream_addr", w_addr, (k < S1 - 1) ? k + 1 : S1 - 1);
      chk("stream_weights", mac_weights, rom[k]);
      chk("stream_out_valid", out_valid, 0);
    end
    mac_rdy = 1'b0;
    for (int d = 0; d < 16; d++) begin
      step();
      layer_out = {$urandom, $urandom};
      mac_rdy   = (d == rdy_dly);
      #1;
      chk("drain_enable", mac_enable, 0);
      chk("drain_out_valid", out_valid, 0);
      chk("drain_err", err, err_model);
      if (mac_rdy) begin
        exp_q.push_back(layer_out);
        break;
      end
    end
    if (rdy_dly < 0 || rdy_dly >= 16) begin
      step();
      mac_rdy   = 1'b0;
      err_model = 1'b1;
      #1;
      chk("timeout_err", err, 1);
      chk("timeout_out_valid", out_valid, 0);
      chk("timeout_in_ready", in_ready, 1);
      return;
    end
    step();
    mac_rdy   = 1'b0;
    layer_out = {$urandom, $urandom};
    #1;
    expv = exp_q.pop_front();
    chk("out_valid_rise", out_valid, 1);
    chk("out_vector", out_vector, expv);
    for (int h = 0; h < hold; h++) begin
      step();
      layer_out = {$urandom, $urandom};
      #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_vector", out_vector, expv);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    chk("done_out_valid", out_valid, 0);
    chk("done_in_ready", in_ready, 1);
    chk("done_err", err, err_model);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    int a0;
    fill_rom_random();

    // reset state
    step(); step();
    #1;
    chk("rst_mac_reset", mac_reset, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_out_vector", out_vector, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enable", mac_enable, 0);
    chk("rst_state", dbg_state, 0);
    reset = 1'b1;
    #1;
    chk("rst_release_mac_reset", mac_reset, 1);
    chk("rst_release_in_ready", in_ready, 1);

    // reset mid-STREAM aborts
    in_vector = {$urandom, $urandom};
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step(); step();
    #1;
    chk("abort_in_stream", mac_enable, 1);
    reset = 1'b0;
    #1;
    chk("abort_mac_reset_comb", mac_reset, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      chk("abort_mac_reset", mac_reset, 0);
      chk("abort_busy", busy, 0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_state", dbg_state, 0);
    end
    reset = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    step();

    // directed: samples 0x10..0x80, ROM row k all k+1, lanes ready 2 cycles after
    // enable falls, result held for 5 cycles
    for (int k = 0; k < S1; k++) begin
      v[k*DW +: DW] = 8'((k + 1) << 4);
      rom[k] = {S2{8'(k + 1)}};
    end
    run_txn(v, 2, 5, 1'b0, 1'b0);

    // in_valid held across two evaluations: exactly two acceptances
    a0 = acc_cnt;
    fill_rom_random();
    run_txn({$urandom, $urandom}, 2, 1, 1'b1, 1'b0);
    run_txn({$urandom, $urandom}, 0, 0, 1'b0, 1'b0);
    step();
    chk("accept_count", acc_cnt - a0, 2);

    // mac_rdy high throughout STREAM is ignored; capture on last allowed drain cycle
    run_txn({$urandom, $urandom}, 4, 2, 1'b0, 1'b1);
    run_txn({$urandom, $urandom}, 15, 0, 1'b0, 1'b0);

    // randomized evaluations
    for (int t = 0; t < 8; t++) begin
      fill_rom_random();
      run_txn({$urandom, $urandom}, $urandom_range(0, 15), $urandom_range(0, 3),
              1'b0, 1'($urandom_range(0, 1)));
      step();
    end

    // drain timeout: sticky error survives a later good evaluation
    run_txn({$urandom, $urandom}, 16, 0, 1'b0, 1'b0);
    step(); step();
    #1;
    chk("err_sticky_idle", err, 1);
    run_txn({$urandom, $urandom}, 3, 1, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    err_model = 1'b0;
    #1;
    chk("err_cleared_by_reset", err, 0);
    step();
    run_txn({$urandom, $urandom}, 1, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
